// File: rtl/shared_inc_adder_pkg.sv
// Shared types and helpers for the round-robin arbitrated increment-adder.
package shared_inc_adder_pkg;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_WIDTH   = 4;
    localparam int unsigned DEF_ID_W    = 2;
    localparam int unsigned MAX_REQ     = 8;
    localparam int unsigned PTR_W       = 3;

    // Ceiling log2, used to validate the requester ID width.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // One-hot round-robin pick: first asserted valid at or after ptr, modulo n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [PTR_W-1:0]   ptr,
        input int unsigned        n
    );
        logic [MAX_REQ-1:0] gnt;
        int unsigned        idx;
        gnt = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = (32'(ptr) + i) % n;
            if ((i < n) && (gnt == '0) && valid[PTR_W'(idx)]) begin
                gnt[PTR_W'(idx)] = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/inc_adder_reg.sv
// Registered A + B + 1 datapath with owner ID, loaded on an accepted request.
module inc_adder_reg
    import shared_inc_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned ID_W  = DEF_ID_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [ID_W-1:0]  id,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic [ID_W-1:0]  id_q
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(1);
    end

    // Fields hold their last value when not loading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res   <= '0;
            carry <= 1'b0;
            id_q  <= '0;
        end else if (load) begin
            {carry, res} <= sum;
            id_q         <= id;
        end
    end

endmodule

// File: rtl/shared_inc_adder_arb.sv
// Round-robin arbiter sharing one registered increment-adder among NUM_REQ requesters.
module shared_inc_adder_arb
    import shared_inc_adder_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned ID_W    = DEF_ID_W,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_res,
    output logic                     rsp_carry,
    output logic [CNT_W-1:0]         op_count
);

    if (ID_W != clog2(NUM_REQ)) begin : g_bad_id_w
        $error("ID_W must equal clog2(NUM_REQ)");
    end

    logic                 slot_free;
    logic                 accept;
    logic [MAX_REQ-1:0]   pick;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      sel_id;
    logic [ID_W-1:0]      ptr_next;
    logic [WIDTH-1:0]     sel_a;
    logic [WIDTH-1:0]     sel_b;

    if (NUM_REQ < MAX_REQ) begin : g_pick_pad
        logic unused_pick;
        assign unused_pick = ^pick[MAX_REQ-1:NUM_REQ];
    end

    // Grant only when the response slot can take a result this edge.
    always_comb begin
        slot_free = !rsp_valid || rsp_ready;
        pick      = rr_pick(MAX_REQ'(req_valid), PTR_W'(ptr), NUM_REQ);
        grant     = '0;
        if (enable && slot_free) begin
            grant = pick[NUM_REQ-1:0];
        end
        accept = |grant;
    end

    assign req_ready = grant;

    // Operand and ID mux driven by the one-hot grant.
    always_comb begin
        sel_id = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_id = ID_W'(i);
                sel_a  = req_a[i*WIDTH +: WIDTH];
                sel_b  = req_b[i*WIDTH +: WIDTH];
            end
        end
        if (sel_id == ID_W'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = sel_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Pointer moves just past the winner so it becomes lowest priority next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= ptr_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (accept && (op_count != '1)) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

    inc_adder_reg #(
        .WIDTH (WIDTH),
        .ID_W  (ID_W)
    ) u_inc_adder_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .a     (sel_a),
        .b     (sel_b),
        .id    (sel_id),
        .res   (rsp_res),
        .carry (rsp_carry),
        .id_q  (rsp_id)
    );

endmodule

// File: tb/tb_shared_inc_adder_arb.sv
// Randomized and directed bench for shared_inc_adder_arb against a cycle-level reference model.
module tb_shared_inc_adder_arb;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int IDW = 2;
    localparam int CW  = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [W-1:0]     rsp_res;
    logic             rsp_carry;
    logic [CW-1:0]    op_count;

    int n_checks = 0;
    int n_errors = 0;

    int opa [N];
    int opb [N];
    bit pend [N];

    // Reference model state
    int m_valid, m_id, m_res, m_carry, m_cnt, m_ptr, m_gnt;

    shared_inc_adder_arb #(
        .NUM_REQ (N),
        .WIDTH   (W),
        .ID_W    (IDW),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res),
        .rsp_carry (rsp_carry),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_id = 0; m_res = 0; m_carry = 0; m_cnt = 0; m_ptr = 0; m_gnt = -1;
    endtask

    // Called at a falling edge with inputs chosen; checks, advances model, returns at next falling edge.
    task automatic step();
        int g, full;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'(opa[i]);
            req_b[i*W +: W] = W'(opb[i]);
        end
        #1;
        g = -1;
        if (enable && (m_valid == 0 || rsp_ready)) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        m_gnt = g;
        check("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        check("rsp_id",    32'(rsp_id),    32'(m_id));
        check("rsp_res",   32'(rsp_res),   32'(m_res));
        check("rsp_carry", 32'(rsp_carry), 32'(m_carry));
        check("op_count",  32'(op_count),  32'(m_cnt));
        if (g >= 0) begin
            full    = opa[g] + opb[g] + 1;
            m_res   = full % 16;
            m_carry = full / 16;
            m_id    = g;
            m_valid = 1;
            m_ptr   = (g + 1) % N;
            if (m_cnt < 255) m_cnt++;
        end else if (rsp_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_res",   32'(rsp_res),   32'd0);
        check("rst_count", 32'(op_count),  32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic single(input int id, input int a, input int b, input int exp_res, input int exp_c);
        req_valid = 4'(1 << id);
        opa[id] = a; opb[id] = b;
        step();
        req_valid = '0;
        check("sgl_res",   32'(rsp_res),   32'(exp_res));
        check("sgl_carry", 32'(rsp_carry), 32'(exp_c));
        check("sgl_id",    32'(rsp_id),    32'(id));
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin opa[i] = 0; opb[i] = 0; pend[i] = 0; end
        model_reset();
        @(negedge clk);
        do_reset();

        // Single request from requester 2
        enable = 1'b1; rsp_ready = 1'b1;
        req_valid = 4'b0100; opa[2] = 3; opb[2] = 4;
        #1 check("single_grant", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        check("single_valid", 32'(rsp_valid), 32'd1);
        check("single_res",   32'(rsp_res),   32'd8);
        check("single_id",    32'(rsp_id),    32'd2);
        check("single_count", 32'(op_count),  32'd1);

        // Round-robin with all requesters valid
        do_reset();
        enable = 1'b1; rsp_ready = 1'b1; req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1 check("rr_grant", 32'(req_ready), 32'd1 << (k % 4));
            step();
        end
        check("rr_count", 32'(op_count), 32'd5);
        check("rr_last_id", 32'(rsp_id), 32'd0);

        // Backpressure: response held, no grants, then no-bubble overwrite
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_ready0", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        check("bp_nobubble", 32'(rsp_valid), 32'd1);

        // Wrap and carry corners
        do_reset();
        enable = 1'b1; rsp_ready = 1'b1;
        single(0, 15, 15, 15, 1);
        single(0, 7, 8, 0, 1);
        single(0, 0, 0, 1, 0);

        // Enable low drains without granting; then reset mid-operation
        do_reset();
        enable = 1'b1; rsp_ready = 1'b0; req_valid = 4'b0010; opa[1] = 5; opb[1] = 6;
        step();
        enable = 1'b0; req_valid = 4'hF;
        step();
        check("en_hold", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        step();
        check("en_drain", 32'(rsp_valid), 32'd0);
        check("en_res",   32'(rsp_res),   32'd12);
        enable = 1'b1; rsp_ready = 1'b0; req_valid = 4'b0001;
        step();
        check("pre_rst_valid", 32'(rsp_valid), 32'd1);
        #2 rst = 1'b1;
        #1 check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_count", 32'(op_count), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0; enable = 1'b1; rsp_ready = 1'b1; req_valid = 4'hF;
        #1 check("post_rst_grant", 32'(req_ready), 32'b0001);
        step();

        // Randomized traffic with requesters holding until granted
        do_reset();
        for (int c = 0; c < 600; c++) begin
            enable    = ($urandom_range(0, 7) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1;
                    opa[i]  = int'($urandom_range(0, 15));
                    opb[i]  = int'($urandom_range(0, 15));
                end
                req_valid[i] = pend[i];
            end
            step();
            if (m_gnt >= 0) pend[m_gnt] = 0;
        end

        // Saturation of the operation counter
        do_reset();
        enable = 1'b1; rsp_ready = 1'b1; req_valid = 4'hF;
        for (int k = 0; k < 300; k++) begin
            opa[k % N] = k % 16;
            step();
        end
        check("sat_count", 32'(op_count), 32'd255);
        step();
        check("sat_hold", 32'(op_count), 32'd255);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
